// File: rtl/mem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_pkg : shared encodings for the MEM-stage data-memory access unit  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mau_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_access_unit_if : req/ack data-memory bus                          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface mem_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | load_extend : lane select and sign/zero extension of a read word      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (offset_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

    case (size_i)
      SZ_BYTE: result_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: result_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_access_unit : MEM-stage load/store to req/ack bus, stalls the     |
// | pipeline until done. Option macro: MEM_ALIGN_CHECK_EN                  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  MemSize_in,
  input  logic        MemSigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic [31:0] mem_rdata_out,
  output logic        bus_err_out,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        misalign_out,
`endif
  mem_access_unit_if.master dm
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

  mau_state_e  state_q;
  logic [7:0]  cnt_q;
  logic        dm_req_q, dm_we_q;
  logic [31:0] dm_addr_q, dm_wdata_q, mem_rdata_q;
  logic [3:0]  dm_be_q, be_d;
  logic [31:0] wdata_d, ld_data;
  logic        bus_err_q, is_load_q, signed_q;
  logic [1:0]  size_q, off_q;
  logic        op;

  assign op = MemRead_in | MemWrite_in;

  always_comb begin
    be_d    = BE_WORD;
    wdata_d = wdata_in;
    case (MemSize_in)
      SZ_BYTE: begin
        be_d    = BE_BYTE << addr_in[1:0];
        wdata_d = {4{wdata_in[7:0]}};
      end
      SZ_HALF: begin
        be_d    = BE_HALF << {addr_in[1], 1'b0};
        wdata_d = {2{wdata_in[15:0]}};
      end
      default: begin
        be_d    = BE_WORD;
        wdata_d = wdata_in;
      end
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_d, misalign_q;
  always_comb begin
    case (MemSize_in)
      SZ_BYTE: misalign_d = 1'b0;
      SZ_HALF: misalign_d = addr_in[0];
      default: misalign_d = |addr_in[1:0];
    endcase
  end
  assign misalign_out = misalign_q;
`endif

  load_extend u_load_extend (
    .word_i   (dm.dm_rdata),
    .offset_i (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .result_o (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_be_q     <= '0;
      dm_wdata_q  <= '0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
      is_load_q   <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      bus_err_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
`ifdef MEM_ALIGN_CHECK_EN
          // A misaligned access never reaches the bus.
          if (op && misalign_d) begin
            misalign_q <= 1'b1;
            if (MemRead_in) mem_rdata_q <= '0;
            state_q <= ST_DONE;
          end else
`endif
          if (op) begin
            dm_req_q   <= 1'b1;
            dm_we_q    <= MemWrite_in;
            dm_addr_q  <= {addr_in[31:2], 2'b00};
            dm_be_q    <= be_d;
            dm_wdata_q <= wdata_d;
            is_load_q  <= MemRead_in;
            size_q     <= MemSize_in;
            signed_q   <= MemSigned_in;
            off_q      <= addr_in[1:0];
            cnt_q      <= '0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dm.dm_ack) begin
            dm_req_q <= 1'b0;
            if (is_load_q) mem_rdata_q <= ld_data;
            state_q <= ST_DONE;
          end else if (cnt_q == LAST_CNT) begin
            dm_req_q  <= 1'b0;
            bus_err_q <= 1'b1;
            if (is_load_q) mem_rdata_q <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs held low for the whole time reset is asserted.
  assign stall_out     = rst & ((state_q == ST_BUSY) | ((state_q == ST_IDLE) & op));
  assign mem_rdata_out = mem_rdata_q;
  assign bus_err_out   = bus_err_q;
  assign dm.dm_req     = dm_req_q;
  assign dm.dm_we      = dm_we_q;
  assign dm.dm_addr    = dm_addr_q;
  assign dm.dm_be      = dm_be_q;
  assign dm.dm_wdata   = dm_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_access_unit : directed self-checking bench for mem_access_unit |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_in, MemWrite_in, MemSigned_in;
  logic [1:0]  MemSize_in;
  logic [31:0] addr_in, wdata_in;
  logic        stall_out, bus_err_out;
  logic [31:0] mem_rdata_out;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit_if dm_bus ();

  mem_access_unit #(.TIMEOUT_CYC(255)) dut (
    .clk           (clk),
    .rst           (rst),
    .MemRead_in    (MemRead_in),
    .MemWrite_in   (MemWrite_in),
    .MemSize_in    (MemSize_in),
    .MemSigned_in  (MemSigned_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .stall_out     (stall_out),
    .mem_rdata_out (mem_rdata_out),
    .bus_err_out   (bus_err_out),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_out  (misalign_out),
`endif
    .dm            (dm_bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    MemRead_in   = 1'b0;
    MemWrite_in  = 1'b0;
    MemSize_in   = 2'b00;
    MemSigned_in = 1'b0;
    addr_in      = '0;
    wdata_in     = '0;
  endtask

  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_dly, input logic [31:0] rdw, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_res);
    MemRead_in = rd; MemWrite_in = wr; MemSize_in = sz; MemSigned_in = sg;
    addr_in = a; wdata_in = wd;
    #1;
    check({tag, ".stall_idle"}, 32'(stall_out), 32'd1);
    tick();
    check({tag, ".req"},   32'(dm_bus.dm_req), 32'd1);
    check({tag, ".addr"},  dm_bus.dm_addr, exp_addr);
    check({tag, ".be"},    32'(dm_bus.dm_be), 32'(exp_be));
    check({tag, ".we"},    32'(dm_bus.dm_we), 32'(wr));
    if (wr) check({tag, ".wdata"}, dm_bus.dm_wdata, exp_wd);
    for (int i = 0; i < ack_dly; i++) tick();
    check({tag, ".stall_busy"}, 32'(stall_out), 32'd1);
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = rdw;
    tick();
    dm_bus.dm_ack = 1'b0;
    check({tag, ".req_done"},   32'(dm_bus.dm_req), 32'd0);
    check({tag, ".stall_done"}, 32'(stall_out), 32'd0);
    check({tag, ".result"},     mem_rdata_out, exp_res);
    check({tag, ".err"},        32'(bus_err_out), 32'd0);
    clear_inputs();
    tick();
    check({tag, ".stall_after"}, 32'(stall_out), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    dm_bus.dm_ack = 1'b0;
    dm_bus.dm_rdata = '0;
    tick(); tick();
    check("rst.stall", 32'(stall_out), 32'd0);
    check("rst.req",   32'(dm_bus.dm_req), 32'd0);
    check("rst.rdata", mem_rdata_out, 32'd0);
    check("rst.err",   32'(bus_err_out), 32'd0);
    check("rst.be",    32'(dm_bus.dm_be), 32'd0);
    rst = 1'b1;
    tick();

    run_op("lw",  1, 0, 2'b10, 0, 32'h100, 0, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 0, 32'hDEADBEEF);
    run_op("lb",  1, 0, 2'b00, 1, 32'h103, 0, 2, 32'h80112233, 32'h100, 4'b1000, 0, 32'hFFFFFF80);
    run_op("lbu", 1, 0, 2'b00, 0, 32'h103, 0, 1, 32'h80112233, 32'h100, 4'b1000, 0, 32'h00000080);
    run_op("sh",  0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 0, 0, 32'h100, 4'b1100, 32'hABCDABCD, 32'h00000080);
    run_op("sb",  0, 1, 2'b00, 0, 32'h101, 32'h1234565A, 3, 0, 32'h100, 4'b0010, 32'h5A5A5A5A, 32'h00000080);
    run_op("lh",  1, 0, 2'b01, 1, 32'h102, 0, 0, 32'h80017FFF, 32'h100, 4'b1100, 0, 32'hFFFF8001);
    run_op("lhu", 1, 0, 2'b01, 0, 32'h100, 0, 0, 32'h12348765, 32'h100, 4'b0011, 0, 32'h00008765);
    run_op("sw",  0, 1, 2'b10, 0, 32'h10C, 32'h01020304, 0, 0, 32'h10C, 4'b1111, 32'h01020304, 32'h00008765);

`ifdef MEM_ALIGN_CHECK_EN
    MemRead_in = 1'b1; MemSize_in = 2'b10; addr_in = 32'h102;
    #1;
    check("mis.stall_idle", 32'(stall_out), 32'd1);
    tick();
    check("mis.req",   32'(dm_bus.dm_req), 32'd0);
    check("mis.pulse", 32'(misalign_out), 32'd1);
    check("mis.stall", 32'(stall_out), 32'd0);
    check("mis.rdata", mem_rdata_out, 32'd0);
    clear_inputs();
    tick();
    check("mis.pulse_end", 32'(misalign_out), 32'd0);
    check("mis.req_after", 32'(dm_bus.dm_req), 32'd0);
`else
    run_op("lw_mis", 1, 0, 2'b10, 0, 32'h107, 0, 0, 32'hA5A50001, 32'h104, 4'b1111, 0, 32'hA5A50001);
    run_op("lh_mis", 1, 0, 2'b01, 1, 32'h101, 0, 0, 32'h0000F00F, 32'h100, 4'b0011, 0, 32'hFFFFF00F);
`endif

    // Stray ack while idle must be ignored.
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'h55555555;
    tick();
    dm_bus.dm_ack = 1'b0;
    check("stray.req",   32'(dm_bus.dm_req), 32'd0);
    check("stray.stall", 32'(stall_out), 32'd0);
`ifndef MEM_ALIGN_CHECK_EN
    check("stray.rdata", mem_rdata_out, 32'hFFFFF00F);
`endif

    // Timeout abort after 255 BUSY cycles.
    MemRead_in = 1'b1; MemSize_in = 2'b10; addr_in = 32'h200;
    tick();
    for (int i = 0; i < 254; i++) tick();
    check("to.req_last",  32'(dm_bus.dm_req), 32'd1);
    check("to.err_early", 32'(bus_err_out), 32'd0);
    tick();
    check("to.req",   32'(dm_bus.dm_req), 32'd0);
    check("to.err",   32'(bus_err_out), 32'd1);
    check("to.stall", 32'(stall_out), 32'd0);
    check("to.rdata", mem_rdata_out, 32'd0);
    clear_inputs();
    tick();
    check("to.err_end", 32'(bus_err_out), 32'd0);

    // Ack on the final timeout cycle wins.
    MemRead_in = 1'b1; MemSize_in = 2'b10; addr_in = 32'h204;
    tick();
    for (int i = 0; i < 254; i++) tick();
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'h11223344;
    tick();
    dm_bus.dm_ack = 1'b0;
    check("race.err",   32'(bus_err_out), 32'd0);
    check("race.rdata", mem_rdata_out, 32'h11223344);
    clear_inputs();
    tick();

    // Reset during BUSY, then a late ack.
    MemRead_in = 1'b1; MemSize_in = 2'b10; addr_in = 32'h300;
    tick();
    check("rb.req_busy", 32'(dm_bus.dm_req), 32'd1);
    rst = 1'b0;
    tick();
    check("rb.req",   32'(dm_bus.dm_req), 32'd0);
    check("rb.rdata", mem_rdata_out, 32'd0);
    check("rb.stall", 32'(stall_out), 32'd0);
    rst = 1'b1;
    clear_inputs();
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'hCAFEF00D;
    tick();
    dm_bus.dm_ack = 1'b0;
    check("rb.req_ack",   32'(dm_bus.dm_req), 32'd0);
    check("rb.rdata_ack", mem_rdata_out, 32'd0);
    run_op("lw_post", 1, 0, 2'b10, 0, 32'h400, 0, 0, 32'h0BADC0DE, 32'h400, 4'b1111, 0, 32'h0BADC0DE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
